// File: rtl/ps2_rx_pkg.sv
// Shared PS/2 frame definitions for the receiver (and the future transmitter).
package ps2_rx_pkg;

    localparam int unsigned PS2_FRAME_BITS = 11;
    localparam int unsigned DATA_BITS      = PS2_FRAME_BITS - 3;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } ps2_state_e;

    // Odd parity over data plus parity bit means an odd number of ones in total.
    function automatic logic odd_parity_ok(input logic [DATA_BITS-1:0] data, input logic parity);
        return ^{data, parity};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small first-word fall-through FIFO; head is read combinationally from storage.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_core,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full queue still lands.
    assign do_push = push && (!full || pop);
    assign head    = mem_q[rd_ptr_q];

    always_ff @(posedge clk_core or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: line sync and filter, frame FSM, error flags, byte FIFO.
module ps2_rx
    import ps2_rx_pkg::*;
#(
    parameter int unsigned FILTER     = 4,
    parameter int unsigned TIMEOUT    = 2048,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk_core,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       inhibit,
    input  logic       rd,
    input  logic       clr_err,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       err_parity,
    output logic       err_frame,
    output logic       err_overrun
);

    localparam int unsigned FCW = $clog2(FILTER);
    localparam int unsigned TW  = $clog2(TIMEOUT);
    localparam int unsigned BCW = $clog2(DATA_BITS);

    logic           clk_s1_q, clk_s2_q, data_s1_q, data_s2_q;
    logic           clk_f_q, data_f_q, clk_f_prev_q;
    logic [FCW-1:0] clk_cnt_q, data_cnt_q;
    logic           fall;

    ps2_state_e           state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
    logic                 par_q, par_d;
    logic [TW-1:0]        tcnt_q, tcnt_d;
    logic                 err_parity_q, err_parity_d;
    logic                 err_frame_q, err_frame_d;
    logic                 err_overrun_q, err_overrun_d;
    logic                 push, set_par, set_frm, set_ovr, par_ok, timed_out;
    logic                 fifo_full, fifo_empty;

    // Filtered level flips only after FILTER consecutive samples disagree with it.
    always_ff @(posedge clk_core or posedge reset) begin
        if (reset) begin
            clk_s1_q     <= 1'b1;
            clk_s2_q     <= 1'b1;
            data_s1_q    <= 1'b1;
            data_s2_q    <= 1'b1;
            clk_f_q      <= 1'b1;
            data_f_q     <= 1'b1;
            clk_f_prev_q <= 1'b1;
            clk_cnt_q    <= '0;
            data_cnt_q   <= '0;
        end else begin
            clk_s1_q     <= ps2_clk;
            clk_s2_q     <= clk_s1_q;
            data_s1_q    <= ps2_data;
            data_s2_q    <= data_s1_q;
            clk_f_prev_q <= clk_f_q;
            if (clk_s2_q == clk_f_q) begin
                clk_cnt_q <= '0;
            end else if (clk_cnt_q == FCW'(FILTER - 1)) begin
                clk_f_q   <= clk_s2_q;
                clk_cnt_q <= '0;
            end else begin
                clk_cnt_q <= clk_cnt_q + 1'b1;
            end
            if (data_s2_q == data_f_q) begin
                data_cnt_q <= '0;
            end else if (data_cnt_q == FCW'(FILTER - 1)) begin
                data_f_q   <= data_s2_q;
                data_cnt_q <= '0;
            end else begin
                data_cnt_q <= data_cnt_q + 1'b1;
            end
        end
    end

    assign fall = clk_f_prev_q && !clk_f_q;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        par_d     = par_q;
        push      = 1'b0;
        set_par   = 1'b0;
        set_frm   = 1'b0;
        par_ok    = odd_parity_ok(shift_q, par_q);
        timed_out = (state_q != StIdle) && (tcnt_q == TW'(TIMEOUT - 1));
        tcnt_d    = (fall || state_q == StIdle) ? '0 : tcnt_q + 1'b1;

        if (inhibit) begin
            state_d = StIdle;
        end else if (timed_out) begin
            state_d = StIdle;
            set_frm = 1'b1;
        end else if (fall) begin
            case (state_q)
                StIdle: begin
                    if (!data_f_q) begin
                        state_d   = StData;
                        bit_cnt_d = '0;
                    end
                end
                StData: begin
                    shift_d   = {data_f_q, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BCW'(DATA_BITS - 1)) begin
                        state_d = StParity;
                    end
                end
                StParity: begin
                    par_d   = data_f_q;
                    state_d = StStop;
                end
                StStop: begin
                    state_d = StIdle;
                    if (data_f_q && par_ok) begin
                        push = 1'b1;
                    end else begin
                        set_par = !par_ok;
                        set_frm = !data_f_q;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        set_ovr       = push && fifo_full && !rd;
        err_parity_d  = set_par ? 1'b1 : (clr_err ? 1'b0 : err_parity_q);
        err_frame_d   = set_frm ? 1'b1 : (clr_err ? 1'b0 : err_frame_q);
        err_overrun_d = set_ovr ? 1'b1 : (clr_err ? 1'b0 : err_overrun_q);
    end

    always_ff @(posedge clk_core or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            par_q         <= 1'b0;
            tcnt_q        <= '0;
            err_parity_q  <= 1'b0;
            err_frame_q   <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            par_q         <= par_d;
            tcnt_q        <= tcnt_d;
            err_parity_q  <= err_parity_d;
            err_frame_q   <= err_frame_d;
            err_overrun_q <= err_overrun_d;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_core (clk_core),
        .reset    (reset),
        .push     (push),
        .pop      (rd),
        .wdata    (shift_q),
        .head     (rx_data),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign rx_valid    = !fifo_empty;
    assign rx_busy     = (state_q != StIdle);
    assign err_parity  = err_parity_q;
    assign err_frame   = err_frame_q;
    assign err_overrun = err_overrun_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: good/bad frames, timeout, FIFO overrun, inhibit, glitch, reset.
module tb_ps2_rx;

    logic       clk_core = 1'b0;
    logic       reset    = 1'b1;
    logic       ps2_clk  = 1'b1;
    logic       ps2_data = 1'b1;
    logic       inhibit  = 1'b0;
    logic       rd       = 1'b0;
    logic       clr_err  = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, rx_busy, err_parity, err_frame, err_overrun;

    int n_checks = 0;
    int n_pass   = 0;

    ps2_rx dut (
        .clk_core    (clk_core),
        .reset       (reset),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .inhibit     (inhibit),
        .rd          (rd),
        .clr_err     (clr_err),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_busy     (rx_busy),
        .err_parity  (err_parity),
        .err_frame   (err_frame),
        .err_overrun (err_overrun)
    );

    // 10 MHz core clock, so one 20 us PS/2 bit period is 200 core cycles.
    always #50ns clk_core = ~clk_core;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_core);
    endtask

    task automatic pulse_rd();
        @(negedge clk_core);
        rd = 1'b1;
        @(negedge clk_core);
        rd = 1'b0;
        @(negedge clk_core);
    endtask

    task automatic pulse_clr();
        @(negedge clk_core);
        clr_err = 1'b1;
        @(negedge clk_core);
        clr_err = 1'b0;
        @(negedge clk_core);
    endtask

    // Drives the first nbits of a frame; device changes data while the clock is high.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input int nbits, input bit glitch, input bit rd_on_push);
        logic [10:0] bits;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk_core);
            ps2_data = bits[i];
            idle(50);
            if (glitch && i == 4) begin
                ps2_clk = 1'b0;
                @(negedge clk_core);
                ps2_clk = 1'b1;
                idle(20);
            end
            ps2_clk = 1'b0;
            if (rd_on_push && i == 10) begin
                // 2 sync flops + FILTER samples, then the push lands on the 7th edge.
                repeat (6) @(posedge clk_core);
                #1ns rd = 1'b1;
                @(posedge clk_core);
                #1ns rd = 1'b0;
            end
            idle(100);
            ps2_clk = 1'b1;
            idle(50);
        end
        ps2_data = 1'b1;
        idle(20);
    endtask

    task automatic good(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b0, 11, 1'b0, 1'b0);
    endtask

    initial begin
        logic [7:0] exp_q [$];

        idle(3);
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_rx_valid", rx_valid, 0);
        check("reset_rx_busy", rx_busy, 0);
        check("reset_err_parity", err_parity, 0);
        check("reset_err_frame", err_frame, 0);
        check("reset_err_overrun", err_overrun, 0);
        reset = 1'b0;
        idle(5);

        good(8'h1C);
        check("f1c_valid", rx_valid, 1);
        check("f1c_data", rx_data, 8'h1C);
        check("f1c_err_parity", err_parity, 0);
        check("f1c_err_frame", err_frame, 0);
        check("f1c_busy", rx_busy, 0);
        pulse_rd();
        check("f1c_rd_valid", rx_valid, 0);

        send_frame(8'hF0, 1'b1, 1'b0, 11, 1'b0, 1'b0);
        check("par_valid", rx_valid, 0);
        check("par_err_parity", err_parity, 1);
        check("par_err_frame", err_frame, 0);
        pulse_clr();
        check("par_clr", err_parity, 0);

        send_frame(8'h55, 1'b0, 1'b1, 11, 1'b0, 1'b0);
        check("stop_valid", rx_valid, 0);
        check("stop_err_frame", err_frame, 1);
        check("stop_err_parity", err_parity, 0);
        pulse_clr();
        check("stop_clr", err_frame, 0);

        send_frame(8'h33, 1'b0, 1'b0, 5, 1'b0, 1'b0);
        check("tmo_busy_before", rx_busy, 1);
        check("tmo_err_before", err_frame, 0);
        idle(2100);
        check("tmo_err_frame", err_frame, 1);
        check("tmo_busy_after", rx_busy, 0);
        check("tmo_valid", rx_valid, 0);
        pulse_clr();

        for (int i = 1; i <= 5; i++) good(8'(i));
        check("ovr_err_overrun", err_overrun, 1);
        check("ovr_err_frame", err_frame, 0);
        for (int i = 1; i <= 4; i++) begin
            check("ovr_valid", rx_valid, 1);
            check("ovr_order", rx_data, 8'(i));
            pulse_rd();
        end
        check("ovr_drained", rx_valid, 0);
        pulse_clr();
        check("ovr_clr", err_overrun, 0);

        for (int i = 1; i <= 4; i++) good(8'(i));
        send_frame(8'h06, 1'b0, 1'b0, 11, 1'b0, 1'b1);
        check("rdpush_no_overrun", err_overrun, 0);
        exp_q = '{8'h02, 8'h03, 8'h04, 8'h06};
        foreach (exp_q[i]) begin
            check("rdpush_valid", rx_valid, 1);
            check("rdpush_order", rx_data, exp_q[i]);
            pulse_rd();
        end
        check("rdpush_drained", rx_valid, 0);

        send_frame(8'hAA, 1'b0, 1'b0, 4, 1'b0, 1'b0);
        check("inh_busy_before", rx_busy, 1);
        @(negedge clk_core);
        inhibit = 1'b1;
        ps2_clk = 1'b0;
        idle(300);
        check("inh_busy_held", rx_busy, 0);
        ps2_clk = 1'b1;
        idle(200);
        inhibit = 1'b0;
        idle(10);
        good(8'h1C);
        check("inh_valid", rx_valid, 1);
        check("inh_data", rx_data, 8'h1C);
        check("inh_err_frame", err_frame, 0);
        check("inh_err_parity", err_parity, 0);
        pulse_rd();
        check("inh_only_one", rx_valid, 0);

        send_frame(8'hA5, 1'b0, 1'b0, 11, 1'b1, 1'b0);
        check("glitch_valid", rx_valid, 1);
        check("glitch_data", rx_data, 8'hA5);
        check("glitch_err_frame", err_frame, 0);
        check("glitch_err_parity", err_parity, 0);
        pulse_rd();

        good(8'h77);
        send_frame(8'h0F, 1'b1, 1'b0, 11, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b0, 6, 1'b0, 1'b0);
        check("rst_pre_valid", rx_valid, 1);
        check("rst_pre_busy", rx_busy, 1);
        check("rst_pre_err", err_parity, 1);
        @(negedge clk_core);
        reset = 1'b1;
        #1ns;
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_busy", rx_busy, 0);
        check("rst_err_parity", err_parity, 0);
        check("rst_err_frame", err_frame, 0);
        check("rst_err_overrun", err_overrun, 0);
        idle(5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
